// File: rtl/sourceout_pkg.sv
// Shared types and defaults for the source-output scheduler.
// Holds the FSM state encoding and the default FIFO/threshold sizing.
package sourceout_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_USEDW_W       = 18;
    localparam int DEF_START_LEVEL   = 4000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        RD   = 3'd2,
        LAT  = 3'd3,
        SEND = 3'd4,
        GAP  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/sourceout_rr_arb.sv
// Combinational round-robin picker.
// The search starts at last+1 (mod NCH) and returns a one-hot grant plus its index.
module sourceout_rr_arb #(
    parameter int NCH   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCH-1:0]   eligible,
    input  logic [IDX_W-1:0] last,
    output logic [NCH-1:0]   gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin : pick
        int c;
        c     = 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            c = (int'(last) + i) % NCH;
            if (!found && eligible[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/sourceout_sched.sv
// Round-robin scheduler sharing one byte serializer between NCH channel FIFOs.
// Grants an eligible channel, streams data_length bytes, idles blank_length cycles, re-arbitrates.
module sourceout_sched
    import sourceout_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int USEDW_W     = DEF_USEDW_W,
    parameter int START_LEVEL = DEF_START_LEVEL
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    enable,
    input  logic [31:0]             data_length,
    input  logic [31:0]             blank_length,
    input  logic [NCH*USEDW_W-1:0]  ch_usedw,
    input  logic [NCH*BYTE_W-1:0]   ch_data,
    output logic [NCH-1:0]          ch_rden,
    output logic [BYTE_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [NCH-1:0]          grant,
    output logic                    busy,
    output logic [NCH-1:0]          underflow,
    input  logic                    underflow_clr,
    output sched_state_t            state_dbg
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a byte transfers on any cycle with tx_valid && tx_ready. Once tx_valid
    // rises, tx_valid and tx_data hold unchanged until that transfer cycle.

    sched_state_t state_q, state_d;

    logic [NCH-1:0][USEDW_W-1:0] usedw_q;
    logic [NCH-1:0][BYTE_W-1:0]  ch_bytes;
    logic [31:0]                 dlen_q;
    logic [31:0]                 blen_q;
    logic [31:0]                 count_q;
    logic [IDX_W-1:0]            last_idx_q;

    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic             cur_empty;
    logic [BYTE_W-1:0] cur_byte;

    logic ld_len, cnt_clr, cnt_inc, gnt_set, gnt_clr;
    logic rd_fire, uf_set, cap, hs;

    assign ch_bytes  = ch_data;
    assign cur_byte  = ch_bytes[last_idx_q];
    assign cur_empty = (usedw_q[last_idx_q] == '0);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            eligible[i] = (usedw_q[i] > USEDW_W'(START_LEVEL));
        end
    end

    sourceout_rr_arb #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible (eligible),
        .last     (last_idx_q),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .found    (arb_found)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_len  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        gnt_set = 1'b0;
        gnt_clr = 1'b0;
        rd_fire = 1'b0;
        uf_set  = 1'b0;
        cap     = 1'b0;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                ld_len  = 1'b1;
                cnt_clr = 1'b1;
                if (enable) state_d = ARB;
            end
            ARB: begin
                if (!enable) begin
                    gnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (arb_found) begin
                    gnt_set = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (!enable) begin
                    gnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (count_q == dlen_q) begin
                    cnt_clr = 1'b1;
                    if (blen_q == 32'd0) begin
                        gnt_clr = 1'b1;
                        state_d = ARB;
                    end else begin
                        state_d = GAP;
                    end
                end else if (cur_empty) begin
                    uf_set = 1'b1;
                end else begin
                    rd_fire = 1'b1;
                    state_d = LAT;
                end
            end
            LAT: begin
                cap     = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                // A raised byte always completes; enable is not looked at here.
                if (tx_valid && tx_ready) begin
                    hs      = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = RD;
                end
            end
            GAP: begin
                if (!enable) begin
                    gnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (count_q == (blen_q - 32'd1)) begin
                    cnt_clr = 1'b1;
                    gnt_clr = 1'b1;
                    state_d = ARB;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            usedw_q    <= '0;
            dlen_q     <= '0;
            blen_q     <= '0;
            count_q    <= '0;
            last_idx_q <= IDX_W'(NCH - 1);
            grant      <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            underflow  <= '0;
        end else begin
            usedw_q <= ch_usedw;
            if (ld_len) begin
                dlen_q <= data_length;
                blen_q <= blank_length;
            end
            if (cnt_clr) begin
                count_q <= '0;
            end else if (cnt_inc) begin
                count_q <= count_q + 32'd1;
            end
            if (gnt_set) begin
                grant      <= arb_gnt;
                last_idx_q <= arb_idx;
            end else if (gnt_clr) begin
                grant <= '0;
            end
            if (cap) begin
                tx_data  <= cur_byte;
                tx_valid <= 1'b1;
            end else if (hs) begin
                tx_valid <= 1'b0;
            end
            // A fresh underflow in the same cycle as a clear keeps its flag set.
            underflow <= (underflow & ~{NCH{underflow_clr}}) | (uf_set ? grant : '0);
        end
    end

    assign ch_rden   = rd_fire ? grant : '0;
    assign busy      = (state_q != IDLE) && (state_q != ARB);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sourceout_sched.sv
// Directed bench for sourceout_sched: bursts, round robin, backpressure, underflow,
// zero-length rotation, enable drop and asynchronous reset.
module tb_sourceout_sched;
    import sourceout_pkg::*;

    localparam int NCH     = 4;
    localparam int USEDW_W = 18;

    logic                   clk = 1'b0;
    logic                   nRST;
    logic                   enable;
    logic [31:0]            data_length;
    logic [31:0]            blank_length;
    logic [NCH*USEDW_W-1:0] ch_usedw;
    logic [NCH*8-1:0]       ch_data;
    logic [NCH-1:0]         ch_rden;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [NCH-1:0]         grant;
    logic                   busy;
    logic [NCH-1:0]         underflow;
    logic                   underflow_clr;
    sched_state_t           state_dbg;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int         rd_k [NCH];
    int         rden_cnt [NCH];
    int         hs_cnt;
    int         valid_cnt;
    int         rden_cyc_q[$];
    int         hs_cyc_q[$];
    logic [7:0] hs_data_q[$];
    logic [7:0] exp_q[$];
    logic [NCH-1:0] gnt_q[$];
    int         gnt_cyc_q[$];
    logic [NCH-1:0] prev_grant;

    sourceout_sched #(.NCH(NCH), .USEDW_W(USEDW_W), .START_LEVEL(4000)) dut (
        .clk           (clk),
        .nRST          (nRST),
        .enable        (enable),
        .data_length   (data_length),
        .blank_length  (blank_length),
        .ch_usedw      (ch_usedw),
        .ch_data       (ch_data),
        .ch_rden       (ch_rden),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .busy          (busy),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset / models ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input int ch, input int k);
        return 8'((ch * 16 + k) & 8'hff);
    endfunction

    // FIFO model: normal mode, q updates one clock after rden.
    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NCH; i++) rd_k[i] <= 0;
            ch_data <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_rden[i]) begin
                    ch_data[i*8 +: 8] <= pat(i, rd_k[i]);
                    rd_k[i]           <= rd_k[i] + 1;
                end
            end
        end
    end

    // Event logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (!nRST) begin
            for (int i = 0; i < NCH; i++) rden_cnt[i] = 0;
            hs_cnt = 0;
            valid_cnt = 0;
            rden_cyc_q.delete();
            hs_cyc_q.delete();
            hs_data_q.delete();
            gnt_q.delete();
            gnt_cyc_q.delete();
            prev_grant = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_rden[i]) begin
                    rden_cnt[i]++;
                    rden_cyc_q.push_back(cyc);
                end
            end
            if (tx_valid) valid_cnt++;
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                hs_cyc_q.push_back(cyc);
                hs_data_q.push_back(tx_data);
            end
            if (grant != prev_grant && grant != '0) begin
                gnt_q.push_back(grant);
                gnt_cyc_q.push_back(cyc);
            end
            prev_grant = grant;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_usedw(input int ch, input logic [USEDW_W-1:0] v);
        ch_usedw[ch*USEDW_W +: USEDW_W] = v;
    endtask

    task automatic do_reset();
        nRST          = 1'b0;
        enable        = 1'b0;
        tx_ready      = 1'b0;
        underflow_clr = 1'b0;
        data_length   = '0;
        blank_length  = '0;
        ch_usedw      = '0;
        step(3);
        nRST = 1'b1;
        step(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (ch_rden !== 4'b0000) begin errors++; $display("FAIL reset_rden: got %b expected 0000", ch_rden); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        vectors++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (underflow !== 4'b0000) begin errors++; $display("FAIL reset_underflow: got %b expected 0000", underflow); end
        vectors++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_single_burst();
        int c_en;
        do_reset();
        set_usedw(1, 18'd4001);
        data_length  = 32'd3;
        blank_length = 32'd5;
        tx_ready     = 1'b1;
        step(1);
        c_en   = cyc;
        enable = 1'b1;
        step(22);
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(pat(1, k));
        vectors++;
        if (gnt_q.size() < 2 || rden_cyc_q.size() < 4 || hs_cyc_q.size() < 3) begin
            errors++;
            $display("FAIL t1_event_counts: got grants=%0d rden=%0d hs=%0d expected >=2/>=4/>=3",
                     gnt_q.size(), rden_cyc_q.size(), hs_cyc_q.size());
        end else begin
            vectors++; if (gnt_q[0] !== 4'b0010) begin errors++; $display("FAIL t1_grant: got %b expected 0010", gnt_q[0]); end
            vectors++; if (rden_cyc_q[0] !== c_en + 2) begin errors++; $display("FAIL t1_first_rden: got cycle %0d expected %0d", rden_cyc_q[0], c_en + 2); end
            vectors++; if (rden_cyc_q[1] - rden_cyc_q[0] !== 3) begin errors++; $display("FAIL t1_rden_spacing1: got %0d expected 3", rden_cyc_q[1] - rden_cyc_q[0]); end
            vectors++; if (rden_cyc_q[2] - rden_cyc_q[1] !== 3) begin errors++; $display("FAIL t1_rden_spacing2: got %0d expected 3", rden_cyc_q[2] - rden_cyc_q[1]); end
            vectors++; if (hs_cyc_q[0] - rden_cyc_q[0] !== 2) begin errors++; $display("FAIL t1_hs_latency: got %0d expected 2", hs_cyc_q[0] - rden_cyc_q[0]); end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (hs_data_q[k] !== exp_q[k]) begin errors++; $display("FAIL t1_data%0d: got %h expected %h", k, hs_data_q[k], exp_q[k]); end
            end
            // last handshake, RD, 5 gap cycles, ARB, then the next RD read
            vectors++; if (rden_cyc_q[3] - hs_cyc_q[2] !== 8) begin errors++; $display("FAIL t1_gap: got %0d expected 8", rden_cyc_q[3] - hs_cyc_q[2]); end
            vectors++; if (gnt_q[1] !== 4'b0010) begin errors++; $display("FAIL t1_regrant: got %b expected 0010", gnt_q[1]); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_usedw(0, 18'd5000);
        set_usedw(2, 18'd4001);
        data_length  = 32'd1;
        blank_length = 32'd2;
        tx_ready     = 1'b1;
        enable       = 1'b1;
        step(26);
        exp_q.delete();
        exp_q.push_back(pat(0, 0));
        exp_q.push_back(pat(2, 0));
        exp_q.push_back(pat(0, 1));
        vectors++;
        if (gnt_q.size() < 3 || hs_data_q.size() < 3) begin
            errors++;
            $display("FAIL t2_event_counts: got grants=%0d hs=%0d expected >=3", gnt_q.size(), hs_data_q.size());
        end else begin
            vectors++; if (gnt_q[0] !== 4'b0001) begin errors++; $display("FAIL t2_grant0: got %b expected 0001", gnt_q[0]); end
            vectors++; if (gnt_q[1] !== 4'b0100) begin errors++; $display("FAIL t2_grant1: got %b expected 0100", gnt_q[1]); end
            vectors++; if (gnt_q[2] !== 4'b0001) begin errors++; $display("FAIL t2_grant2: got %b expected 0001", gnt_q[2]); end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (hs_data_q[k] !== exp_q[k]) begin errors++; $display("FAIL t2_data%0d: got %h expected %h", k, hs_data_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        do_reset();
        set_usedw(1, 18'd4001);
        data_length  = 32'd2;
        blank_length = 32'd1;
        enable       = 1'b1;
        t = 0;
        while (!tx_valid && t < 20) begin step(1); t++; end
        vectors++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL t3_valid_timeout: got %b expected 1", tx_valid); end
        for (int k = 0; k < 10; k++) begin
            step(1);
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== pat(1, 0) || rden_cnt[1] !== 1 || hs_cnt !== 0) begin
                errors++;
                $display("FAIL t3_hold%0d: got valid=%b data=%h rden=%0d hs=%0d expected 1/%h/1/0",
                         k, tx_valid, tx_data, rden_cnt[1], hs_cnt, pat(1, 0));
            end
        end
        tx_ready = 1'b1;
        step(1);
        vectors++; if (hs_cnt !== 1) begin errors++; $display("FAIL t3_release_hs: got %0d expected 1", hs_cnt); end
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL t3_release_valid: got %b expected 0", tx_valid); end
        step(4);
        vectors++; if (hs_cnt !== 2) begin errors++; $display("FAIL t3_second_byte: got %0d expected 2", hs_cnt); end
    endtask

    task automatic test_underflow();
        int t;
        do_reset();
        set_usedw(3, 18'd4001);
        data_length  = 32'd4;
        blank_length = 32'd1;
        tx_ready     = 1'b1;
        enable       = 1'b1;
        t = 0;
        while (hs_cnt < 1 && t < 30) begin step(1); t++; end
        vectors++; if (hs_cnt !== 1) begin errors++; $display("FAIL t4_first_hs_timeout: got %0d expected 1", hs_cnt); end
        set_usedw(3, 18'd0);
        step(8);
        vectors++; if (underflow !== 4'b1000) begin errors++; $display("FAIL t4_flag: got %b expected 1000", underflow); end
        vectors++; if (rden_cnt[3] !== 2) begin errors++; $display("FAIL t4_no_reads: got %0d expected 2", rden_cnt[3]); end
        vectors++; if (grant !== 4'b1000 || busy !== 1'b1) begin errors++; $display("FAIL t4_held: got grant=%b busy=%b expected 1000/1", grant, busy); end
        underflow_clr = 1'b1;
        step(1);
        vectors++; if (underflow !== 4'b1000) begin errors++; $display("FAIL t4_set_wins: got %b expected 1000", underflow); end
        set_usedw(3, 18'd4001);
        step(2);
        vectors++; if (underflow !== 4'b0000) begin errors++; $display("FAIL t4_clear: got %b expected 0000", underflow); end
        underflow_clr = 1'b0;
        step(5);
        vectors++; if (rden_cnt[3] !== 4 || hs_cnt !== 4) begin errors++; $display("FAIL t4_resume: got rden=%0d hs=%0d expected 4/4", rden_cnt[3], hs_cnt); end
        vectors++;
        if (hs_data_q.size() < 4) begin
            errors++; $display("FAIL t4_data_count: got %0d expected 4", hs_data_q.size());
        end else if (hs_data_q[3] !== pat(3, 3)) begin
            errors++; $display("FAIL t4_data: got %h expected %h", hs_data_q[3], pat(3, 3));
        end
    endtask

    task automatic test_zero_length();
        do_reset();
        set_usedw(1, 18'd4001);
        set_usedw(3, 18'd9000);
        data_length  = 32'd0;
        blank_length = 32'd0;
        tx_ready     = 1'b1;
        enable       = 1'b1;
        step(12);
        vectors++; if (rden_cyc_q.size() !== 0) begin errors++; $display("FAIL t5_reads: got %0d expected 0", rden_cyc_q.size()); end
        vectors++; if (valid_cnt !== 0) begin errors++; $display("FAIL t5_valid: got %0d expected 0", valid_cnt); end
        vectors++;
        if (gnt_q.size() < 4) begin
            errors++; $display("FAIL t5_grant_count: got %0d expected >=4", gnt_q.size());
        end else begin
            vectors++;
            if (gnt_q[0] !== 4'b0010 || gnt_q[1] !== 4'b1000 || gnt_q[2] !== 4'b0010 || gnt_q[3] !== 4'b1000) begin
                errors++;
                $display("FAIL t5_rotation: got %b %b %b %b expected 0010 1000 0010 1000", gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3]);
            end
            vectors++; if (gnt_cyc_q[1] - gnt_cyc_q[0] !== 2) begin errors++; $display("FAIL t5_period: got %0d expected 2", gnt_cyc_q[1] - gnt_cyc_q[0]); end
        end
    endtask

    task automatic test_enable_drop();
        int t;
        do_reset();
        set_usedw(2, 18'd4500);
        data_length  = 32'd3;
        blank_length = 32'd2;
        enable       = 1'b1;
        t = 0;
        while (!tx_valid && t < 20) begin step(1); t++; end
        enable = 1'b0;
        step(2);
        vectors++; if (tx_valid !== 1'b1 || tx_data !== pat(2, 0)) begin errors++; $display("FAIL t6_not_withdrawn: got valid=%b data=%h expected 1/%h", tx_valid, tx_data, pat(2, 0)); end
        tx_ready = 1'b1;
        step(2);
        vectors++; if (hs_cnt !== 1) begin errors++; $display("FAIL t6_byte_done: got %0d expected 1", hs_cnt); end
        vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL t6_idle: got grant=%b busy=%b expected 0000/0", grant, busy); end
        vectors++; if (state_dbg !== IDLE) begin errors++; $display("FAIL t6_state: got %0d expected %0d", state_dbg, IDLE); end
        vectors++; if (rden_cnt[2] !== 1) begin errors++; $display("FAIL t6_reads: got %0d expected 1", rden_cnt[2]); end
    endtask

    task automatic test_reset_in_lat();
        int t;
        do_reset();
        set_usedw(2, 18'd4500);
        data_length  = 32'd2;
        blank_length = 32'd2;
        tx_ready     = 1'b1;
        enable       = 1'b1;
        t = 0;
        while (rden_cnt[2] < 2 && t < 30) begin step(1); t++; end
        vectors++; if (tx_data !== pat(2, 0) || grant !== 4'b0100) begin errors++; $display("FAIL t7_pre: got data=%h grant=%b expected %h/0100", tx_data, grant, pat(2, 0)); end
        nRST = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0000 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || ch_rden !== 4'b0000 || underflow !== 4'b0000) begin
            errors++;
            $display("FAIL t7_async_reset: got grant=%b valid=%b data=%h busy=%b rden=%b uf=%b expected all zero",
                     grant, tx_valid, tx_data, busy, ch_rden, underflow);
        end
        step(2);
        nRST = 1'b1;
        step(1);
    endtask

    initial begin
        nRST          = 1'b0;
        enable        = 1'b0;
        tx_ready      = 1'b0;
        underflow_clr = 1'b0;
        data_length   = '0;
        blank_length  = '0;
        ch_usedw      = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_underflow();
        test_zero_length();
        test_enable_drop();
        test_reset_in_lat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sourceout_sched.md
# sourceout_sched

Round-robin scheduler that shares one serial source-output transmitter between NCH channel FIFOs. It grants one channel at a time once that channel's fill level exceeds a start threshold. It then reads exactly `data_length` bytes from that channel and hands each byte to the transmitter over a valid/ready handshake, inserts a `blank_length`-cycle idle gap, and re-arbitrates. It sits between the per-channel post-FIFOs and the 8-bit UART-style frame serializer.

## Interface
- `NCH`, 4, number of channels (2..8)
- `USEDW_W`, 18, width of each FIFO used-word count
- `START_LEVEL`, 4000, a channel is eligible when its registered usedw > START_LEVEL
- `clk`  in  1  system clock
- `nRST`  in  1  reset; one clock; reset is asynchronous and active-low
- `enable`  in  1  scheduler run enable
- `data_length`  in  32  bytes per burst (latched in IDLE)
- `blank_length`  in  32  gap length in clk cycles (latched in IDLE)
- `ch_usedw`  in  NCH*USEDW_W  packed per-channel FIFO used-word counts, ch0 at LSBs
- `ch_data`  in  NCH*8  packed per-channel FIFO q outputs; normal mode, 1-cycle read latency
- `ch_rden`  out  NCH  per-channel FIFO read enable, at most one bit high
- `tx_data`  out  8  byte to serializer
- `tx_valid`  out  1  byte valid
- `tx_ready`  in  1  serializer accepts byte
- `grant`  out  NCH  one-hot current grant, 0 when none
- `busy`  out  1  high outside IDLE/ARB
- `underflow`  out  NCH  sticky per-channel underflow flags
- `underflow_clr`  in  1  clears all underflow flags

## Operation
- Reset: `ch_rden`=0, `tx_data`=0, `tx_valid`=0, `grant`=0, `busy`=0, `underflow`=0, count=0, last grant=NCH-1, state IDLE.
- `ch_usedw` is registered every cycle; all eligibility and underflow decisions use the registered copy.
- IDLE: latch `data_length`/`blank_length`, clear count; go to ARB if `enable`, else stay.
- ARB: search channels starting at last grant+1 mod NCH; the first eligible channel wins. Set `grant`, update last grant, go to RD. No eligible channel, or `enable`=0: stay, or go to IDLE respectively.
- RD: if count == `data_length`, go to GAP with count cleared. If `blank_length`=0, go to ARB directly and clear `grant`. Else if the registered usedw of the granted channel is 0, set `underflow[grant]`, issue no read, and stay. Else pulse `ch_rden[grant]` for one cycle and go to LAT.
- LAT: capture `ch_data` of the granted channel into `tx_data`, assert `tx_valid`, go to SEND.
- SEND: hold `tx_valid` and `tx_data` until `tx_valid && tx_ready`. On that cycle, deassert `tx_valid`, increment count, go to RD.
- GAP: `tx_valid`=0. Count cycles 0..`blank_length`-1. On the last cycle, clear count and `grant` and go to ARB.
- `enable` low is honoured only in IDLE, ARB, RD and GAP, and causes a transition to IDLE with `grant` cleared. A byte in LAT/SEND is always completed first; `tx_valid` is never withdrawn once it has been raised.
- `data_length`=0: each grant goes straight from RD to GAP and no reads occur.
- `underflow_clr` clears the flags. A simultaneous new underflow event wins over the clear.
- Count is 32-bit unsigned; compares are unsigned equality. Both lengths are latched, so input changes mid-run take effect only after IDLE.

## Timing
- Eligibility latency: usedw change to ARB decision is 1 cycle (register); grant is visible the cycle after the ARB decision.
- Per byte with `tx_ready` tied high: 3 cycles (RD, LAT, SEND), so `ch_rden` can pulse at most once per 3 cycles.
- `tx_data` is valid in the same cycle `tx_valid` rises, and is stable until the handshake.
- Gap: exactly `blank_length` cycles with `tx_valid`=0 between the last handshake+1 and the next ARB.
- Reset mid-operation: all outputs return to their reset values asynchronously; any partially read FIFO word is discarded.

## Structure
- Package `sourceout_pkg`: state enum (IDLE, ARB, RD, LAT, SEND, GAP), default START_LEVEL, USEDW_W, byte width.
- Sub-module `sourceout_rr_arb`: combinational round-robin pick from an eligible vector and last grant. It returns a one-hot grant and a found flag.
- Top holds the FSM, usedw register, count, output registers and data mux.

## Test plan
- NCH=4, ch1 usedw=4001, others 0, `data_length`=3, `blank_length`=5, `tx_ready`=1 -> `grant`=0010; three `ch_rden[1]` pulses 3 cycles apart; three handshakes carrying ch1 data; 5-cycle gap; re-grant of ch1.
- ch0 and ch2 both eligible, last grant=3 -> grants alternate ch0, ch2, ch0 across bursts.
- `tx_ready` low for 10 cycles during SEND -> `tx_valid`/`tx_data` held constant; no extra `ch_rden`; count unchanged.
- Granted ch3 usedw drops to 0 mid-burst -> `underflow[3]`=1, no reads; resumes when usedw>0; `underflow_clr` clears the flag.
- `data_length`=0, `blank_length`=0 -> grant rotates through eligible channels every 2 cycles, zero `ch_rden` and zero `tx_valid`.
- `enable` dropped in SEND -> current byte completes, then IDLE with `grant`=0. `nRST` asserted in LAT -> all outputs 0 immediately.
